// File: rtl/snn_pkg.sv
// Shared types and constants for the snn batch scheduler.
//   sched_state_t : scheduler FSM encoding
//   NO_RESULT     : digit written to the result buffer when a sample hangs
package snn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_RECORD,
        ST_DONE
    } sched_state_t;

    localparam logic [3:0] NO_RESULT = 4'hF;

endpackage

// File: rtl/snn_watchdog.sv
// Per-sample watchdog for the batch scheduler.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : zero the count (highest priority after reset)
//   enable    : advance the count by one this cycle
//   expired   : count has reached TIMEOUT_CYCLES-1, i.e. this is the last
//               allowed cycle of the wait
module snn_watchdog #(
    parameter int TIMEOUT_CYCLES = 60000,
    parameter int TO_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST_CNT = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] CNT_ONE  = TO_W'(1);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_ONE;
        end
    end

    assign expired = (count == LAST_CNT);

endmodule

// File: rtl/snn_batch_sched.sv
// Batch scheduler for snn_core: classifies NUM_SAMPLES input images one after
// another, stores each digit in a result buffer and scores it against a label.
//   clk, rst     : clock, synchronous active-high reset
//   batch_start  : batch request, only honoured in IDLE
//   core_done    : core done level; its rising edge marks a valid core_digit
//   core_digit   : digit classified by the core
//   exp_digit    : label for the current sample_sel (combinational ROM)
//   sample_sel   : index of the sample being classified (input-RAM select)
//   core_start   : one-cycle start pulse to the core
//   res_we/addr/data : result-buffer write port, NO_RESULT on a hung sample
//   pass_cnt     : samples whose digit matched the label in this batch
//   to_cnt       : samples that hit the watchdog in this batch
//   batch_busy   : batch in progress (LAUNCH of sample 0 through DONE)
//   batch_done   : one-cycle pulse at the end of a batch
module snn_batch_sched
    import snn_pkg::*;
#(
    parameter int NUM_SAMPLES    = 10,
    parameter int SEL_W          = 4,
    parameter int TIMEOUT_CYCLES = 60000,
    parameter int TO_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             batch_start,
    input  logic             core_done,
    input  logic [3:0]       core_digit,
    input  logic [3:0]       exp_digit,
    output logic [SEL_W-1:0] sample_sel,
    output logic             core_start,
    output logic             res_we,
    output logic [SEL_W-1:0] res_addr,
    output logic [3:0]       res_data,
    output logic [SEL_W:0]   pass_cnt,
    output logic [SEL_W:0]   to_cnt,
    output logic             batch_busy,
    output logic             batch_done
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_SAMPLES - 1);
    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
    localparam logic [SEL_W:0]   CNT_ONE  = (SEL_W + 1)'(1);

    sched_state_t state, state_nxt;

    logic       done_q;
    logic       done_edge;
    logic       ok_q;       // 1: sample finished by core_done, 0: by watchdog
    logic [3:0] digit_q;
    logic       wd_clear;
    logic       wd_en;
    logic       wd_expired;
    logic       last_sample;

    // done_q follows core_done every cycle, so a level still high from the
    // previous sample never looks like a fresh completion.
    assign done_edge   = core_done & ~done_q;
    assign last_sample = (sample_sel == LAST_SEL);
    assign wd_clear    = (state == ST_LAUNCH);
    assign wd_en       = (state == ST_WAIT);

    snn_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_en),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        core_start = 1'b0;
        res_we     = 1'b0;
        res_data   = '0;
        batch_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (batch_start) state_nxt = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                core_start = 1'b1;
                state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                // A done edge on the watchdog's final cycle still counts as
                // a completion; ok_q is resolved the same way below.
                if (done_edge || wd_expired) state_nxt = ST_RECORD;
            end
            ST_RECORD: begin
                res_we    = 1'b1;
                res_data  = ok_q ? digit_q : NO_RESULT;
                state_nxt = last_sample ? ST_DONE : ST_LAUNCH;
            end
            ST_DONE: begin
                batch_done = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign res_addr   = sample_sel;
    assign batch_busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            sample_sel <= '0;
            pass_cnt   <= '0;
            to_cnt     <= '0;
        end else begin
            done_q <= core_done;
            case (state)
                ST_IDLE: begin
                    if (batch_start) begin
                        sample_sel <= '0;
                        pass_cnt   <= '0;
                        to_cnt     <= '0;
                    end
                end
                ST_WAIT: begin
                    if (done_edge) begin
                        ok_q <= 1'b1;
                    end else if (wd_expired) begin
                        ok_q <= 1'b0;
                    end
                end
                ST_RECORD: begin
                    if (ok_q) begin
                        if (digit_q == exp_digit) pass_cnt <= pass_cnt + CNT_ONE;
                    end else begin
                        to_cnt <= to_cnt + CNT_ONE;
                    end
                    // The final index is left in place so it reads back
                    // after the batch completes.
                    if (!last_sample) sample_sel <= sample_sel + SEL_ONE;
                end
                default: ;
            endcase
        end
    end

    // Captured digit is pure data and only read on the ok path.
    always_ff @(posedge clk) begin
        if (state == ST_WAIT && done_edge) digit_q <= core_digit;
    end

endmodule
